// File: rtl/bgm_sequencer.sv
// Background-music sequencer: walks a note ROM and emits a fixed-rate square-wave
// PCM stream to the I2S serializer over a valid/ready handshake.
module bgm_sequencer #(
  parameter int unsigned       SAMPLE_DIV = 1042,
  parameter int unsigned       DUR_UNIT   = 256,
  parameter int unsigned       ADDR_W     = 6,
  parameter logic signed [15:0] AMP       = 16'sd4096
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [19:0]       rom_data,
  output logic [15:0]       sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam int unsigned DUR_W = 8 + $clog2(DUR_UNIT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY} state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [11:0]      half_period;
  logic [11:0]      phase_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic             polarity;
  logic             tick, play_tick;
  logic             start_ok, loop_restart, note_load, note_end, song_done;
  logic [15:0]      sample_val;

  assign busy      = (state != S_IDLE);
  assign tick      = busy && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign play_tick = (state == S_PLAY) && tick && !stop;
  assign sample_val = (half_period == '0) ? '0 : (polarity ? AMP : -AMP);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d      = state;
    start_ok     = 1'b0;
    loop_restart = 1'b0;
    note_load    = 1'b0;
    note_end     = 1'b0;
    song_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_d  = S_FETCH;
          start_ok = 1'b1;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (rom_data[7:0] == 8'd0) begin
          if (loop_en) begin
            state_d      = S_FETCH;
            loop_restart = 1'b1;
          end else begin
            state_d   = S_IDLE;
            song_done = 1'b1;
          end
        end else begin
          state_d   = S_PLAY;
          note_load = 1'b1;
        end
      end
      S_PLAY: begin
        if (play_tick && dur_cnt == DUR_W'(1)) begin
          state_d  = S_FETCH;
          note_end = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // stop overrides every other transition once playback is underway
    if (stop && state != S_IDLE) begin
      state_d      = S_IDLE;
      loop_restart = 1'b0;
      note_load    = 1'b0;
      note_end     = 1'b0;
      song_done    = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt      <= '0;
      rom_addr     <= '0;
      half_period  <= '0;
      phase_cnt    <= '0;
      dur_cnt      <= '0;
      polarity     <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // divider runs across note boundaries so sample spacing never slips
      div_cnt <= (state == S_IDLE || tick) ? '0 : div_cnt + DIV_W'(1);
      done    <= song_done;

      if (start_ok || loop_restart) rom_addr <= '0;
      else if (note_end)            rom_addr <= rom_addr + ADDR_W'(1);

      if (start_ok) begin
        overrun  <= 1'b0;
        polarity <= 1'b1;
      end

      if (note_load) begin
        half_period <= rom_data[19:8];
        dur_cnt     <= DUR_W'(rom_data[7:0]) * DUR_W'(DUR_UNIT);
        phase_cnt   <= '0;
        polarity    <= 1'b1;
      end else if (play_tick) begin
        dur_cnt <= dur_cnt - DUR_W'(1);
        if (half_period != '0) begin
          if (phase_cnt == half_period - 12'd1) begin
            phase_cnt <= '0;
            polarity  <= ~polarity;
          end else begin
            phase_cnt <= phase_cnt + 12'd1;
          end
        end
      end

      if (play_tick) begin
        sample_data  <= sample_val;
        sample_valid <= 1'b1;
        if (sample_valid && !sample_ready) overrun <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bgm_sequencer.sv
// Bench for bgm_sequencer: directed and randomized songs checked against a
// song-level model of the expected sample stream, timing and handshake.
module tb_bgm_sequencer;

  localparam int unsigned SDIV  = 4;
  localparam int unsigned DUNIT = 2;
  localparam int unsigned AW    = 3;
  localparam int unsigned NENT  = 2 ** AW;
  localparam logic [15:0] POS   = 16'h1000;
  localparam logic [15:0] NEG   = 16'hF000;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic          sample_ready = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [19:0]   rom_data = '0;
  logic [15:0]   sample_data;
  logic          sample_valid, busy, done, overrun;

  logic [19:0]   mem [NENT];
  int unsigned   n_checks = 0;
  int unsigned   n_pass = 0;
  int unsigned   n_fail = 0;
  int unsigned   cyc = 0;
  int unsigned   samp_cyc_q[$];
  logic [15:0]   samp_val_q[$];
  logic [AW-1:0] addr_q[$];
  int unsigned   done_cnt = 0;
  int unsigned   done_cyc = 0;
  logic [15:0]   exp_q[$];

  bgm_sequencer #(
    .SAMPLE_DIV(SDIV),
    .DUR_UNIT  (DUNIT),
    .ADDR_W    (AW),
    .AMP       (16'sd4096)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    cyc      <= cyc + 1;
    rom_data <= mem[rom_addr];
  end

  always @(negedge Clk) begin
    if (!Reset_n) begin
      samp_cyc_q.delete();
      samp_val_q.delete();
      addr_q.delete();
      addr_q.push_back('0);
      done_cnt = 0;
    end else begin
      if (sample_valid && sample_ready) begin
        samp_cyc_q.push_back(cyc);
        samp_val_q.push_back(sample_data);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rom_addr != addr_q[$]) addr_q.push_back(rom_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(negedge Clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    stop  = 1'b0;
    #1 Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  task automatic pulse_start(output int unsigned c0);
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50 && !sample_valid; i++) sync();
    check({tag, "_valid_seen"}, sample_valid, 1);
  endtask

  // Expected sample stream: each note gives dur*DUNIT samples, square wave
  // starting high, flipping every half_period samples; half_period 0 is silence.
  function automatic void model_song();
    int addr;
    int h;
    int n;
    exp_q.delete();
    addr = 0;
    for (int e = 0; e < int'(NENT); e++) begin
      if (mem[addr][7:0] == 8'd0) break;
      h = int'(mem[addr][19:8]);
      n = int'(mem[addr][7:0]) * int'(DUNIT);
      for (int k = 0; k < n; k++)
        exp_q.push_back((h == 0) ? 16'h0000 : (((k / h) % 2) == 0 ? POS : NEG));
      addr = (addr + 1) % int'(NENT);
    end
  endfunction

  task automatic run_song(input string tag);
    int unsigned c0;
    int unsigned n;
    model_song();
    loop_en      = 1'b0;
    sample_ready = 1'b1;
    do_reset();
    pulse_start(c0);
    sync();
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_addr_after_start"}, rom_addr, 0);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) sync();
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_cyc, c0 + SDIV * exp_q.size() + 2);
    check({tag, "_sample_count"}, samp_val_q.size(), exp_q.size());
    n = (samp_val_q.size() < exp_q.size()) ? samp_val_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++) begin
      check($sformatf("%s_val%0d", tag, i), samp_val_q[i], exp_q[i]);
      check($sformatf("%s_cyc%0d", tag, i), samp_cyc_q[i], c0 + (i + 1) * SDIV);
    end
    sync();
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int unsigned c0;
    int unsigned nn;
    for (int i = 0; i < int'(NENT); i++) mem[i] = '0;

    // reset values
    repeat (2) sync();
    check("rst_addr", rom_addr, 0);
    check("rst_data", sample_data, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    @(posedge Clk); #1 Reset_n = 1'b1;

    mem[0] = {12'd2, 8'd1}; mem[1] = '0;
    run_song("half2");
    mem[0] = {12'd1, 8'd2};
    run_song("half1");
    mem[0] = {12'd0, 8'd1};
    run_song("rest");
    mem[0] = '0;
    run_song("empty");

    for (int it = 0; it < 5; it++) begin
      nn = $urandom_range(0, 4);
      for (int e = 0; e < int'(NENT); e++)
        mem[e] = {12'($urandom_range(0, 5)), 8'($urandom_range(1, 3))};
      mem[nn] = '0;
      run_song($sformatf("rnd%0d", it));
    end

    // looping song alternates between entry 0 and the end marker
    do_reset();
    mem[0] = {12'd1, 8'd1}; mem[1] = '0;
    loop_en = 1'b1; sample_ready = 1'b1;
    pulse_start(c0);
    repeat (60) sync();
    check("loop_addr_len", addr_q.size() >= 6, 1);
    for (int i = 0; i < 6 && i < addr_q.size(); i++)
      check($sformatf("loop_addr%0d", i), addr_q[i], i % 2);
    check("loop_no_done", done_cnt, 0);
    check("loop_busy", busy, 1);
    @(posedge Clk); #1 stop = 1'b1;
    @(posedge Clk); #1 stop = 1'b0;
    sync();
    check("loop_stop_busy", busy, 0);
    loop_en = 1'b0;

    // address wraps past the last entry
    do_reset();
    for (int e = 0; e < int'(NENT); e++) mem[e] = {12'd1, 8'd1};
    pulse_start(c0);
    for (int i = 0; i < 300 && addr_q.size() < NENT + 1; i++) sync();
    check("wrap_len", addr_q.size() >= NENT + 1, 1);
    for (int i = 0; i < int'(NENT) + 1 && i < addr_q.size(); i++)
      check($sformatf("wrap_addr%0d", i), addr_q[i], i % int'(NENT));
    @(posedge Clk); #1 stop = 1'b1;
    @(posedge Clk); #1 stop = 1'b0;

    // overrun with stalled serializer, then reset mid-play
    do_reset();
    for (int e = 0; e < int'(NENT); e++) mem[e] = '0;
    mem[0] = {12'd1, 8'd8};
    sample_ready = 1'b0;
    pulse_start(c0);
    wait_valid("ovr");
    check("ovr_first", sample_data, POS);
    check("ovr_clear_first", overrun, 0);
    repeat (2) sync();
    check("ovr_stable", sample_data, POS);
    repeat (2) sync();
    check("ovr_second", sample_data, NEG);
    check("ovr_valid_held", sample_valid, 1);
    check("ovr_flag", overrun, 1);
    @(posedge Clk); #1 sample_ready = 1'b1;
    @(posedge Clk); #1 sample_ready = 1'b0;
    sync();
    check("ovr_valid_fall", sample_valid, 0);
    check("ovr_xfer_count", samp_val_q.size(), 1);
    if (samp_val_q.size() > 0) check("ovr_xfer_val", samp_val_q[0], NEG);
    check("ovr_sticky", overrun, 1);
    check("mid_busy", busy, 1);
    @(posedge Clk); #1 Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    sync();
    check("mid_rst_addr", rom_addr, 0);
    check("mid_rst_data", sample_data, 0);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_overrun", overrun, 0);
    @(posedge Clk); #1 Reset_n = 1'b1;

    // stop with a sample pending holds it until accepted
    do_reset();
    sample_ready = 1'b0;
    pulse_start(c0);
    wait_valid("stop");
    @(posedge Clk); #1 stop = 1'b1;
    @(posedge Clk); #1 stop = 1'b0;
    sync();
    check("stop_busy", busy, 0);
    check("stop_valid_held", sample_valid, 1);
    repeat (6) sync();
    check("stop_valid_still", sample_valid, 1);
    check("stop_data_still", sample_data, POS);
    check("stop_no_done", done_cnt, 0);
    @(posedge Clk); #1 sample_ready = 1'b1;
    @(posedge Clk); #1 sample_ready = 1'b0;
    sync();
    check("stop_valid_fall", sample_valid, 0);
    check("stop_xfer_count", samp_val_q.size(), 1);

    // start and stop together from idle
    do_reset();
    sample_ready = 1'b1;
    @(posedge Clk); #1 begin start = 1'b1; stop = 1'b1; end
    @(posedge Clk); #1 begin start = 1'b0; stop = 1'b0; end
    sync();
    check("ss_busy1", busy, 0);
    repeat (3) sync();
    check("ss_busy4", busy, 0);
    check("ss_no_done", done_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bgm_sequencer.md
Name: bgm_sequencer

Overview:
Background-music controller for the audio path. Walks a note table in an external synchronous ROM and turns each entry into a fixed-rate stream of square-wave PCM samples. Hands each sample to the I2S serializer over a valid/ready handshake. Software or game logic drives it with start/stop/loop controls. Sits between the note ROM and the I2S transmitter in the top level.

Parameters:
SAMPLE_DIV, 1042, Clk cycles per sample tick (50 MHz / 1042 ≈ 48 kHz); minimum 4.
DUR_UNIT, 256, sample ticks per duration unit.
ADDR_W, 6, note ROM address width.
AMP, 16'sd4096, square-wave amplitude.

Ports:
Clk  in  1  system clock.
Reset_n  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle pulse; begin song at entry 0.
stop  in  1  one-cycle pulse; abort playback.
loop_en  in  1  at end marker, restart at entry 0 instead of stopping.
rom_addr  out  ADDR_W  note ROM address.
rom_data  in  20  entry; [19:8] half_period in samples (0 = rest); [7:0] duration in DUR_UNITs (0 = end marker).
sample_data  out  16  signed PCM sample.
sample_valid  out  1  sample_data valid.
sample_ready  in  1  serializer accepts sample.
busy  out  1  high in any state but IDLE.
done  out  1  one-cycle pulse on non-looping end of song.
overrun  out  1  sticky; a tick occurred while a sample was still unaccepted.

Behaviour:
- Reset (async, Reset_n=0): all outputs 0. State=IDLE. All counters 0. overrun is cleared only by reset or start.
- States: IDLE, FETCH, WAIT, PLAY.
- ROM timing: 1-cycle read latency. rom_addr presented in FETCH; rom_data is sampled at the end of WAIT.
- IDLE:
  - On start: rom_addr←0, clear overrun, reset tick divider and polarity, go to FETCH.
  - stop is ignored.
- FETCH → WAIT unconditionally.
- WAIT: latch half_period and duration.
  - If duration=0 (end marker) and loop_en=1: rom_addr←0, go to FETCH.
  - If duration=0 and loop_en=0: pulse done, go to IDLE.
  - Otherwise: dur_cnt←duration×DUR_UNIT, phase_cnt←0, go to PLAY.
- Tick divider:
  - Free-runs from 0 to SAMPLE_DIV-1 while busy; tick fires on wrap.
  - Held at 0 in IDLE.
  - Not reset between notes, so the sample rate stays exact across note boundaries.
  - A FETCH/WAIT pair takes 2 cycles and always finishes between ticks.
- PLAY, on each tick:
  - Sample value: rest gives 0; otherwise polarity=1 gives +AMP and polarity=0 gives −AMP.
  - Load sample_data and set sample_valid=1 in the same cycle.
  - phase_cnt increments. When phase_cnt reaches half_period-1, polarity toggles and phase_cnt←0.
  - Polarity starts at 1 on each new note.
  - dur_cnt decrements. When it reaches 0: rom_addr←rom_addr+1 (wraps from 2^ADDR_W-1 to 0), go to FETCH.
- Handshake:
  - sample_valid & sample_ready in a cycle: transfer; sample_valid←0 next cycle unless a tick occurs in the same cycle.
  - sample_data is stable while valid=1 and ready=0.
  - Tick while valid=1 and not ready in that cycle: new sample overwrites, valid stays 1, overrun←1.
- stop in any non-IDLE state: go to IDLE next cycle; busy←0; no done pulse. A pending sample_valid is held until accepted.
- Simultaneous events:
  - start and stop together: stop wins.
  - start while busy: ignored.
  - done and start in the same cycle: start in the following cycle is honoured normally.

Test Plan:
- Reset mid-PLAY (Reset_n low for 3 cycles) → all outputs 0, state IDLE, overrun cleared.
- SAMPLE_DIV=4, DUR_UNIT=2, ROM {0:(half=2,dur=1), 1:(dur=0)}, ready tied 1, start → rom_addr 0, busy next cycle. Two samples each 4 cycles apart: +4096, +4096. Then done pulse, busy=0.
- Same ROM with half=1, dur=2 → four samples: +4096, −4096, +4096, −4096. Entry (half=0, dur=1) → two samples of 0.
- loop_en=1 with end marker at entry 1 → rom_addr sequence 0,1,0,1…; no done; busy stays 1.
- sample_ready held 0 across two ticks → sample_data shows the second sample, overrun=1. Raise ready → one transfer, valid falls.
- stop during PLAY with valid pending and ready=0 → IDLE next cycle, valid held until ready=1. start+stop in the same cycle from IDLE → stays IDLE.
